press_classifier: RTL and testbench
===================================

PRESS_CLASSIFIER -- requirements
Module: press_classifier

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of the hold-time counter.
REQ-002 Parameter LONG_TICKS, default 50000, SHALL set the number of qualifying ticks held before a long press; legal range 1..2^CNT_W-1.
REQ-003 Parameter REPEAT_TICKS, default 10000, SHALL set the number of qualifying ticks between auto-repeat pulses; legal range 1..2^CNT_W-1.
REQ-004 CLK  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 RST  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 deb_in  input  1  SHALL carry the debounced, already-synchronous button level from the debouncer FSM output.
REQ-007 tick  input  1  SHALL be the time-base enable; a cycle with tick=1 is a qualifying tick.
REQ-008 short_press  output  1  SHALL pulse for one cycle when a press is released before the long threshold.
REQ-009 long_press  output  1  SHALL pulse for one cycle when a press crosses the long threshold.
REQ-010 repeat_pulse  output  1  SHALL pulse for one cycle at each auto-repeat interval after a long press.
REQ-011 long_release  output  1  SHALL pulse for one cycle when a press is released after a long press.
REQ-012 rep_count  output  8  SHALL hold the number of repeat pulses issued for the current or most recent press.
REQ-013 busy  output  1  SHALL be 1 whenever the state is not IDLE.

Function
REQ-014 States SHALL be IDLE, PRESSED and LONG_HELD; the encoding is free, and any unused encoding SHALL return to IDLE on the next edge.
REQ-015 A registered copy deb_prev SHALL be kept, and a press SHALL be detected only when deb_prev=0 and deb_in=1.
REQ-016 IDLE to PRESSED SHALL occur on a detected press, with the counter cleared to 0 and rep_count cleared to 0.
REQ-017 In PRESSED with deb_in=0, the block SHALL move to IDLE and assert short_press for one cycle.
REQ-018 In PRESSED with deb_in=1 and tick=1, the counter SHALL increment; when the pre-increment value equals LONG_TICKS-1, the block SHALL move to LONG_HELD, assert long_press, and clear the counter.
REQ-019 If release and the terminal tick occur in the same cycle in PRESSED, release SHALL win: only short_press is asserted.
REQ-020 In LONG_HELD with deb_in=1 and tick=1, the counter SHALL increment; when the pre-increment value equals REPEAT_TICKS-1, the block SHALL assert repeat_pulse, clear the counter, and increment rep_count.
REQ-021 rep_count SHALL saturate at 255, while repeat_pulse continues to fire.
REQ-022 In LONG_HELD with deb_in=0, the block SHALL move to IDLE and assert long_release, with no repeat_pulse that cycle even if a terminal tick coincides.
REQ-023 With tick=0, the counter SHALL hold its value and no threshold event SHALL occur.
REQ-024 All pulse outputs SHALL be registered and asserted in the cycle immediately after the edge at which the triggering condition is sampled (latency 1 cycle).
REQ-025 At most one pulse output SHALL be high in any cycle.
REQ-026 rep_count SHALL hold its value in IDLE until the next detected press.
REQ-027 A new press SHALL NOT be detected in the cycle in which the block returns to IDLE; detection requires deb_in to be observed low first.

Reset
REQ-028 While RST=1, state SHALL be IDLE, the counter 0, rep_count 0, and all pulse outputs and busy 0, applied immediately without waiting for a clock edge.
REQ-029 deb_prev SHALL reset to 1, so a button held through reset release produces no event until it is released and pressed again.
REQ-030 Reset asserted mid-press (PRESSED or LONG_HELD) SHALL abort the press silently, with no short_press or long_release emitted.

Verification (LONG_TICKS=4, REPEAT_TICKS=2, tick=1 unless stated)
REQ-031 deb_in=1 held through RST release, then held for 10 cycles -> no pulses and busy=0; after deb_in goes 0 then 1 -> busy=1.
REQ-032 Press held for 3 cycles, then released -> short_press=1 for exactly one cycle; long_press never asserts; rep_count=0.
REQ-033 Press held for 8 cycles, then released -> long_press on the 4th tick, repeat_pulse on ticks 6 and 8, rep_count=2, then long_release once; rep_count stays 2 in IDLE.
REQ-034 Release coincident with the 4th tick -> short_press only; no long_press.
REQ-035 Press with tick=0 for 20 cycles, then release -> short_press only; RST pulsed in LONG_HELD -> all outputs 0 asynchronously and no long_release.
REQ-036 Press held for 520 cycles -> rep_count saturates at 255 and repeat_pulse keeps firing every 2 cycles.

Source files
------------

// File: rtl/press_classifier.sv
// Classifies debounced button presses into short, long, auto-repeat and long-release events.
// All event outputs are registered single-cycle pulses; busy reflects any non-idle state.
module press_classifier #(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned LONG_TICKS   = 50000,
    parameter int unsigned REPEAT_TICKS = 10000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       deb_in,
    input  logic       tick,
    output logic       short_press,
    output logic       long_press,
    output logic       repeat_pulse,
    output logic       long_release,
    output logic [7:0] rep_count,
    output logic       busy
);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StPressed  = 2'd1,
        StLongHeld = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_TICKS - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       rep_q;
    logic             deb_prev_q;
    logic             short_q;
    logic             long_q;
    logic             repeat_q;
    logic             lrel_q;

    // deb_prev resets high so a button held through reset must be released before it counts.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rep_q      <= '0;
            deb_prev_q <= 1'b1;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
            lrel_q     <= 1'b0;
        end else begin
            deb_prev_q <= deb_in;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
            lrel_q     <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (!deb_prev_q && deb_in) begin
                        state_q <= StPressed;
                        cnt_q   <= '0;
                        rep_q   <= '0;
                    end
                end
                StPressed: begin
                    // Release takes priority over a coincident terminal tick.
                    if (!deb_in) begin
                        state_q <= StIdle;
                        short_q <= 1'b1;
                    end else if (tick) begin
                        if (cnt_q == LongLast) begin
                            state_q <= StLongHeld;
                            long_q  <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                StLongHeld: begin
                    if (!deb_in) begin
                        state_q <= StIdle;
                        lrel_q  <= 1'b1;
                    end else if (tick) begin
                        if (cnt_q == RepeatLast) begin
                            repeat_q <= 1'b1;
                            cnt_q    <= '0;
                            if (rep_q != 8'hFF) begin
                                rep_q <= rep_q + 8'd1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign repeat_pulse = repeat_q;
    assign long_release = lrel_q;
    assign rep_count    = rep_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier with LONG_TICKS=4 and REPEAT_TICKS=2.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_press_classifier;

    logic       CLK;
    logic       RST;
    logic       deb_in;
    logic       tick;
    logic       short_press;
    logic       long_press;
    logic       repeat_pulse;
    logic       long_release;
    logic [7:0] rep_count;
    logic       busy;

    int total;
    int bad;

    press_classifier #(
        .CNT_W        (16),
        .LONG_TICKS   (4),
        .REPEAT_TICKS (2)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .deb_in       (deb_in),
        .tick         (tick),
        .short_press  (short_press),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .long_release (long_release),
        .rep_count    (rep_count),
        .busy         (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected vector layout: {short, long, repeat, long_release, busy, rep_count}.
    function automatic logic [12:0] ev(input logic sp, input logic lp, input logic rp,
                                       input logic lr, input logic bz, input logic [7:0] rc);
        return {sp, lp, rp, lr, bz, rc};
    endfunction

    task automatic chk(input string tag, input logic [12:0] exp);
        logic [12:0] obs;
        obs = {short_press, long_press, repeat_pulse, long_release, busy, rep_count};
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b (sp lp rp lr busy rep_count)", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        RST    = 1'b1;
        deb_in = 1'b1;
        tick   = 1'b1;
        #1;
        chk("reset_async", ev(0, 0, 0, 0, 0, 8'd0));
        cyc();
        cyc();
        chk("reset_held", ev(0, 0, 0, 0, 0, 8'd0));
        RST = 1'b0;

        // Button held through reset release: nothing happens.
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("held_thru_reset", ev(0, 0, 0, 0, 0, 8'd0));
        end
        deb_in = 1'b0;
        cyc();
        chk("low_seen", ev(0, 0, 0, 0, 0, 8'd0));
        deb_in = 1'b1;
        cyc();
        chk("repress_busy", ev(0, 0, 0, 0, 1, 8'd0));
        deb_in = 1'b0;
        cyc();
        chk("repress_short", ev(1, 0, 0, 0, 0, 8'd0));
        cyc();
        chk("short_one_cycle", ev(0, 0, 0, 0, 0, 8'd0));

        // Short press: 3 ticks held, then release.
        deb_in = 1'b1;
        cyc();
        chk("short_detect", ev(0, 0, 0, 0, 1, 8'd0));
        for (int i = 1; i <= 3; i++) begin
            cyc();
            chk("short_hold", ev(0, 0, 0, 0, 1, 8'd0));
        end
        deb_in = 1'b0;
        cyc();
        chk("short_pulse", ev(1, 0, 0, 0, 0, 8'd0));
        cyc();
        chk("short_after", ev(0, 0, 0, 0, 0, 8'd0));

        // Long press: long at tick 4, repeats at ticks 6 and 8, then long_release.
        deb_in = 1'b1;
        cyc();
        chk("long_detect", ev(0, 0, 0, 0, 1, 8'd0));
        for (int t = 1; t <= 8; t++) begin
            logic [7:0] rc;
            rc = (t >= 8) ? 8'd2 : (t >= 6) ? 8'd1 : 8'd0;
            cyc();
            chk("long_hold", ev(0, t == 4, t == 6 || t == 8, 0, 1, rc));
        end
        deb_in = 1'b0;
        cyc();
        chk("long_release", ev(0, 0, 0, 1, 0, 8'd2));
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rep_count_kept", ev(0, 0, 0, 0, 0, 8'd2));
        end

        // Release coincident with the 4th tick: short only, rep_count cleared by the press.
        deb_in = 1'b1;
        cyc();
        chk("race_detect", ev(0, 0, 0, 0, 1, 8'd0));
        for (int i = 1; i <= 3; i++) begin
            cyc();
            chk("race_hold", ev(0, 0, 0, 0, 1, 8'd0));
        end
        deb_in = 1'b0;
        cyc();
        chk("race_short", ev(1, 0, 0, 0, 0, 8'd0));
        cyc();
        chk("race_after", ev(0, 0, 0, 0, 0, 8'd0));

        // No ticks: counter frozen, release gives short.
        tick   = 1'b0;
        deb_in = 1'b1;
        cyc();
        chk("notick_detect", ev(0, 0, 0, 0, 1, 8'd0));
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("notick_hold", ev(0, 0, 0, 0, 1, 8'd0));
        end
        deb_in = 1'b0;
        cyc();
        chk("notick_short", ev(1, 0, 0, 0, 0, 8'd0));
        cyc();

        // Reset in LONG_HELD after one repeat: immediate clear, no long_release.
        tick   = 1'b1;
        deb_in = 1'b1;
        cyc();
        chk("rst_detect", ev(0, 0, 0, 0, 1, 8'd0));
        for (int t = 1; t <= 6; t++) begin
            cyc();
            chk("rst_hold", ev(0, t == 4, t == 6, 0, 1, (t == 6) ? 8'd1 : 8'd0));
        end
        RST = 1'b1;
        #1;
        chk("rst_mid_async", ev(0, 0, 0, 0, 0, 8'd0));
        deb_in = 1'b0;
        cyc();
        chk("rst_mid_held", ev(0, 0, 0, 0, 0, 8'd0));
        RST = 1'b0;
        cyc();
        chk("rst_no_lrel", ev(0, 0, 0, 0, 0, 8'd0));
        cyc();
        chk("rst_idle", ev(0, 0, 0, 0, 0, 8'd0));

        // 520 ticks held: rep_count saturates at 255 (tick 514), repeats keep firing.
        deb_in = 1'b1;
        cyc();
        chk("sat_detect", ev(0, 0, 0, 0, 1, 8'd0));
        for (int t = 1; t <= 520; t++) begin
            int n;
            n = (t >= 4) ? (t - 4) / 2 : 0;
            if (n > 255) n = 255;
            cyc();
            chk("sat_hold", ev(0, t == 4, t >= 6 && (t % 2) == 0, 0, 1, 8'(n)));
        end
        deb_in = 1'b0;
        cyc();
        chk("sat_release", ev(0, 0, 0, 1, 0, 8'd255));
        cyc();
        chk("sat_idle", ev(0, 0, 0, 0, 0, 8'd255));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
